// File: rtl/imem_loader_if.sv
// Handshake and memory-write bus of the instruction-memory loader.
// The source/bench side uses master; the loader itself uses slave.
interface imem_loader_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned LEN_W  = 9
);
    logic              START;
    logic [ADDR_W-1:0] BASE_ADDR;
    logic [LEN_W-1:0]  LOAD_LEN;
    logic              ABORT;
    logic              WR_VALID;
    logic [31:0]       WR_DATA;
    logic              WR_READY;
    logic              MEM_WE;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [7:0]        MEM_DATA;
    logic              BUSY;
    logic              DONE;
    logic              ALIGN_ERR;
    logic [LEN_W-1:0]  WORD_COUNT;

    modport master (
        output START, BASE_ADDR, LOAD_LEN, ABORT, WR_VALID, WR_DATA,
        input  WR_READY, MEM_WE, MEM_ADDR, MEM_DATA, BUSY, DONE, ALIGN_ERR, WORD_COUNT
    );

    modport slave (
        input  START, BASE_ADDR, LOAD_LEN, ABORT, WR_VALID, WR_DATA,
        output WR_READY, MEM_WE, MEM_ADDR, MEM_DATA, BUSY, DONE, ALIGN_ERR, WORD_COUNT
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: accepts 32-bit words over valid/ready and writes them
// big-endian, one byte per cycle, into a byte-addressed memory starting at a base.
module imem_loader #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned LEN_W  = 9
) (
    input logic          CLK,
    input logic          RESET,
    imem_loader_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle,
        StAccept,
        StWrite,
        StFinish
    } state_e;

    state_e            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_count;
    logic [31:0]       r_word;
    logic [1:0]        r_idx;
    logic              r_wr_ready;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [7:0]        r_mem_data;
    logic              r_done;
    logic              r_align_err;

    logic [1:0]        w_idx_inc;
    logic [LEN_W-1:0]  w_count_inc;
    logic [ADDR_W-1:0] w_next_byte_addr;
    logic [7:0]        w_next_byte;

    assign w_idx_inc        = r_idx + 2'd1;
    assign w_count_inc      = r_count + LEN_W'(1);
    assign w_next_byte_addr = r_addr + ADDR_W'(w_idx_inc);

    // Byte lane for the next index; MSB goes to the lowest address.
    always_comb begin
        w_next_byte = r_word[31:24];
        unique case (w_idx_inc)
            2'd0: w_next_byte = r_word[31:24];
            2'd1: w_next_byte = r_word[23:16];
            2'd2: w_next_byte = r_word[15:8];
            2'd3: w_next_byte = r_word[7:0];
            default: w_next_byte = r_word[31:24];
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state     <= StIdle;
            r_addr      <= '0;
            r_len       <= '0;
            r_count     <= '0;
            r_word      <= '0;
            r_idx       <= '0;
            r_wr_ready  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_data  <= '0;
            r_done      <= 1'b0;
            r_align_err <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_align_err <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (bus.START) begin
                        if (bus.BASE_ADDR[1:0] != 2'b00) begin
                            r_align_err <= 1'b1;
                        end else if (bus.LOAD_LEN == '0) begin
                            r_count <= '0;
                            r_done  <= 1'b1;
                            r_state <= StFinish;
                        end else begin
                            r_addr     <= bus.BASE_ADDR;
                            r_len      <= bus.LOAD_LEN;
                            r_count    <= '0;
                            r_wr_ready <= 1'b1;
                            r_state    <= StAccept;
                        end
                    end
                end

                StAccept: begin
                    if (bus.ABORT) begin
                        r_wr_ready <= 1'b0;
                        r_state    <= StIdle;
                    end else if (bus.WR_VALID && r_wr_ready) begin
                        // Word is captured here; later WR_DATA changes cannot reach the bytes.
                        r_word     <= bus.WR_DATA;
                        r_idx      <= 2'd0;
                        r_wr_ready <= 1'b0;
                        r_mem_we   <= 1'b1;
                        r_mem_addr <= r_addr;
                        r_mem_data <= bus.WR_DATA[31:24];
                        r_state    <= StWrite;
                    end
                end

                StWrite: begin
                    if (bus.ABORT) begin
                        r_mem_we <= 1'b0;
                        r_state  <= StIdle;
                    end else if (r_idx == 2'd3) begin
                        r_mem_we <= 1'b0;
                        r_addr   <= r_addr + ADDR_W'(4);
                        r_count  <= w_count_inc;
                        if (w_count_inc == r_len) begin
                            r_done  <= 1'b1;
                            r_state <= StFinish;
                        end else begin
                            r_wr_ready <= 1'b1;
                            r_state    <= StAccept;
                        end
                    end else begin
                        r_idx      <= w_idx_inc;
                        r_mem_addr <= w_next_byte_addr;
                        r_mem_data <= w_next_byte;
                    end
                end

                StFinish: begin
                    r_state <= StIdle;
                end

                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign bus.WR_READY   = r_wr_ready;
    assign bus.MEM_WE     = r_mem_we;
    assign bus.MEM_ADDR   = r_mem_addr;
    assign bus.MEM_DATA   = r_mem_data;
    assign bus.BUSY       = (r_state != StIdle);
    assign bus.DONE       = r_done;
    assign bus.ALIGN_ERR  = r_align_err;
    assign bus.WORD_COUNT = r_count;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed scenarios plus randomized sessions,
// checked against a byte-level model of big-endian word placement with wrap-around.
module tb_imem_loader;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned LEN_W  = 9;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

    imem_loader #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .CLK  (clk),
        .RESET(rst_n),
        .bus  (bus)
    );

    typedef struct {
        int                cyc;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } wr_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          align_cnt = 0;
    wr_t         wr_q[$];
    int          hs_q[$];
    int          done_q[$];
    logic        rdy_h[int];
    logic        we_h[int];
    logic [31:0] wq[$];

    // Monitor: samples pre-edge values at every rising edge.
    initial forever begin
        @(posedge clk);
        cyc++;
        rdy_h[cyc] = bus.WR_READY;
        we_h[cyc]  = bus.MEM_WE;
        if (bus.WR_VALID && bus.WR_READY) hs_q.push_back(cyc);
        if (bus.MEM_WE) wr_q.push_back('{cyc, bus.MEM_ADDR, bus.MEM_DATA});
        if (bus.DONE) done_q.push_back(cyc);
        if (bus.ALIGN_ERR) align_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Reference: byte j of the session lands at base + j (mod depth), MSB first.
    function automatic void model_byte(input logic [ADDR_W-1:0] base, input int j,
                                       output logic [ADDR_W-1:0] a, output logic [7:0] d);
        int unsigned i = j / 4;
        int unsigned b = j % 4;
        a = ADDR_W'((int'(base) + j) % DEPTH);
        d = 8'(wq[i] >> (8 * (3 - b)));
    endfunction

    task automatic clear_mon();
        wr_q.delete();
        hs_q.delete();
        done_q.delete();
        align_cnt = 0;
    endtask

    task automatic start_req(input logic [ADDR_W-1:0] base, input int len, input bit abort_too);
        @(negedge clk);
        bus.START     = 1'b1;
        bus.BASE_ADDR = base;
        bus.LOAD_LEN  = LEN_W'(len);
        bus.ABORT     = abort_too;
        @(negedge clk);
        bus.START     = 1'b0;
        bus.ABORT     = 1'b0;
        bus.BASE_ADDR = ADDR_W'($urandom);
        bus.LOAD_LEN  = LEN_W'($urandom);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap, input bit noise, output bit ok);
        for (int g = 0; g < gap; g++) begin
            bus.WR_VALID  = 1'b0;
            bus.WR_DATA   = $urandom;
            bus.START     = noise && ($urandom_range(1, 0) == 1);
            bus.BASE_ADDR = ADDR_W'($urandom);
            @(negedge clk);
        end
        bus.START    = 1'b0;
        bus.WR_VALID = 1'b1;
        bus.WR_DATA  = w;
        ok = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if (bus.WR_READY) begin
                @(negedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        bus.WR_VALID = 1'b0;
        bus.WR_DATA  = $urandom;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (!bus.BUSY) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic drive_session(input logic [ADDR_W-1:0] base, input int gap_lo, input int gap_hi,
                                 input bit noise, input bit abort_too, output bit ok);
        bit got;
        clear_mon();
        start_req(base, wq.size(), abort_too);
        ok = 1'b1;
        foreach (wq[i]) begin
            send_word(wq[i], $urandom_range(gap_hi, gap_lo), noise, got);
            ok = ok & got;
        end
        wait_idle(got);
        ok = ok & got;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_cmp++;
        if ({bus.WR_READY, bus.MEM_WE, bus.MEM_ADDR, bus.MEM_DATA, bus.BUSY, bus.DONE,
             bus.ALIGN_ERR, bus.WORD_COUNT} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got we=%b rdy=%b addr=%0d data=%h busy=%b done=%b ae=%b wc=%0d want all 0",
                     bus.MEM_WE, bus.WR_READY, bus.MEM_ADDR, bus.MEM_DATA, bus.BUSY, bus.DONE,
                     bus.ALIGN_ERR, bus.WORD_COUNT);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.BUSY !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle: busy=%b want 0", bus.BUSY);
        end
    endtask

    // Shared by single/wrap/gap/random: byte stream, timing, DONE and count.
    task automatic test_single();
        bit ok;
        logic [ADDR_W-1:0] ea;
        logic [7:0] ed;
        wq = '{32'h0001_1020};
        drive_session(ADDR_W'(0), 0, 0, 1'b0, 1'b0, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL single_timeout: got timeout want completion"); end
        n_cmp++;
        if (wr_q.size() != 4) begin
            n_bad++; $display("FAIL single_nwrites: got %0d want 4", wr_q.size());
        end
        for (int j = 0; j < wr_q.size() && j < 4; j++) begin
            model_byte(ADDR_W'(0), j, ea, ed);
            n_cmp++;
            if (wr_q[j].addr !== ea || wr_q[j].data !== ed || wr_q[j].cyc !== hs_q[0] + 1 + j) begin
                n_bad++;
                $display("FAIL single_byte%0d: got (%0d,%h)@%0d want (%0d,%h)@%0d", j, wr_q[j].addr,
                         wr_q[j].data, wr_q[j].cyc, ea, ed, hs_q[0] + 1 + j);
            end
        end
        n_cmp++;
        if (done_q.size() != 1 || done_q[0] != hs_q[0] + 5) begin
            n_bad++; $display("FAIL single_done: got %0d pulses want 1 at %0d", done_q.size(), hs_q[0] + 5);
        end
        n_cmp++;
        if (bus.WORD_COUNT !== LEN_W'(1)) begin
            n_bad++; $display("FAIL single_count: got %0d want 1", bus.WORD_COUNT);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        logic [ADDR_W-1:0] ea;
        logic [7:0] ed;
        wq = '{32'h0064_2824, 32'h0127_4025};
        drive_session(ADDR_W'(1020), 0, 0, 1'b0, 1'b0, ok);
        n_cmp++;
        if (!ok || wr_q.size() != 8 || hs_q.size() != 2) begin
            n_bad++; $display("FAIL wrap_nwrites: got %0d writes ok=%0b want 8", wr_q.size(), ok);
        end
        for (int j = 0; j < wr_q.size() && j < 8; j++) begin
            model_byte(ADDR_W'(1020), j, ea, ed);
            n_cmp++;
            if (wr_q[j].addr !== ea || wr_q[j].data !== ed || wr_q[j].cyc !== hs_q[j/4] + 1 + j%4) begin
                n_bad++;
                $display("FAIL wrap_byte%0d: got (%0d,%h) want (%0d,%h)", j, wr_q[j].addr,
                         wr_q[j].data, ea, ed);
            end
        end
        n_cmp++;
        if (done_q.size() != 1 || bus.WORD_COUNT !== LEN_W'(2)) begin
            n_bad++; $display("FAIL wrap_done: got %0d pulses wc=%0d want 1 and 2", done_q.size(), bus.WORD_COUNT);
        end
    endtask

    task automatic test_gap();
        bit ok;
        logic [ADDR_W-1:0] ea;
        logic [7:0] ed;
        wq = '{$urandom, $urandom, $urandom};
        drive_session(ADDR_W'(64), 7, 7, 1'b0, 1'b0, ok);
        n_cmp++;
        if (!ok || wr_q.size() != 12 || hs_q.size() != 3) begin
            n_bad++; $display("FAIL gap_nwrites: got %0d writes ok=%0b want 12", wr_q.size(), ok);
        end else begin
            for (int i = 0; i < 2; i++) begin
                for (int c = hs_q[i] + 5; c <= hs_q[i+1]; c++) begin
                    n_cmp++;
                    if (rdy_h[c] !== 1'b1 || we_h[c] !== 1'b0) begin
                        n_bad++; $display("FAIL gap_wait@%0d: got rdy=%b we=%b want 1 0", c, rdy_h[c], we_h[c]);
                    end
                end
            end
            for (int j = 0; j < 12; j++) begin
                model_byte(ADDR_W'(64), j, ea, ed);
                n_cmp++;
                if (wr_q[j].addr !== ea || wr_q[j].data !== ed) begin
                    n_bad++; $display("FAIL gap_byte%0d: got (%0d,%h) want (%0d,%h)", j, wr_q[j].addr,
                                      wr_q[j].data, ea, ed);
                end
            end
            n_cmp++;
            if (done_q.size() != 1 || done_q[0] != hs_q[2] + 5) begin
                n_bad++; $display("FAIL gap_done: got %0d pulses want 1 at %0d", done_q.size(), hs_q[2] + 5);
            end
        end
    endtask

    task automatic test_align();
        bit ok;
        logic [ADDR_W-1:0] ea;
        logic [7:0] ed;
        clear_mon();
        start_req(ADDR_W'(6), 3, 1'b0);
        for (int t = 0; t < 3; t++) begin
            n_cmp++;
            if (bus.BUSY !== 1'b0) begin n_bad++; $display("FAIL align_busy: got %b want 0", bus.BUSY); end
            @(negedge clk);
        end
        n_cmp++;
        if (align_cnt != 1 || wr_q.size() != 0) begin
            n_bad++; $display("FAIL align_pulse: got %0d pulses %0d writes want 1 and 0", align_cnt, wr_q.size());
        end
        wq = '{$urandom, $urandom};
        drive_session(ADDR_W'(8), 0, 2, 1'b0, 1'b0, ok);
        n_cmp++;
        if (!ok || wr_q.size() != 8 || done_q.size() != 1 || align_cnt != 0) begin
            n_bad++; $display("FAIL align_followup: got %0d writes %0d done ok=%0b want 8 1", wr_q.size(),
                              done_q.size(), ok);
        end
        for (int j = 0; j < wr_q.size() && j < 8; j++) begin
            model_byte(ADDR_W'(8), j, ea, ed);
            n_cmp++;
            if (wr_q[j].addr !== ea || wr_q[j].data !== ed) begin
                n_bad++; $display("FAIL align_byte%0d: got (%0d,%h) want (%0d,%h)", j, wr_q[j].addr,
                                  wr_q[j].data, ea, ed);
            end
        end
    endtask

    // ABORT is raised in the cycle that shows byte 1, so the byte-2 step never happens.
    task automatic test_abort();
        bit ok;
        logic [ADDR_W-1:0] base;
        logic [ADDR_W-1:0] ea;
        logic [7:0] ed;
        base = ADDR_W'($urandom_range(255, 0) * 4);
        wq = '{$urandom, $urandom};
        clear_mon();
        start_req(base, 2, 1'b0);
        send_word(wq[0], 0, 1'b0, ok);
        @(negedge clk);
        n_cmp++;
        if (!ok || bus.MEM_WE !== 1'b1 || bus.MEM_ADDR !== base + ADDR_W'(1)) begin
            n_bad++; $display("FAIL abort_setup: got we=%b addr=%0d want 1 %0d", bus.MEM_WE, bus.MEM_ADDR,
                              base + ADDR_W'(1));
        end
        bus.ABORT = 1'b1;
        @(negedge clk);
        bus.ABORT = 1'b0;
        n_cmp++;
        if (bus.BUSY !== 1'b0 || bus.MEM_WE !== 1'b0 || bus.WR_READY !== 1'b0) begin
            n_bad++; $display("FAIL abort_idle: got busy=%b we=%b rdy=%b want 0 0 0", bus.BUSY, bus.MEM_WE,
                              bus.WR_READY);
        end
        repeat (6) @(negedge clk);
        n_cmp++;
        if (wr_q.size() != 2 || done_q.size() != 0 || bus.WORD_COUNT !== '0) begin
            n_bad++; $display("FAIL abort_result: got %0d writes %0d done wc=%0d want 2 0 0", wr_q.size(),
                              done_q.size(), bus.WORD_COUNT);
        end
        for (int j = 0; j < wr_q.size() && j < 2; j++) begin
            model_byte(base, j, ea, ed);
            n_cmp++;
            if (wr_q[j].addr !== ea || wr_q[j].data !== ed) begin
                n_bad++; $display("FAIL abort_byte%0d: got (%0d,%h) want (%0d,%h)", j, wr_q[j].addr,
                                  wr_q[j].data, ea, ed);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        wq = '{$urandom, $urandom};
        clear_mon();
        start_req(ADDR_W'(128), 2, 1'b0);
        send_word(wq[0], 0, 1'b0, ok);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.MEM_WE !== 1'b0 || bus.BUSY !== 1'b0 || bus.WR_READY !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_drop: got we=%b busy=%b rdy=%b want 0 0 0", bus.MEM_WE, bus.BUSY,
                              bus.WR_READY);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (!ok || bus.BUSY !== 1'b0 || bus.WORD_COUNT !== '0 || wr_q.size() != 1) begin
            n_bad++; $display("FAIL rstmid_idle: got busy=%b wc=%0d writes=%0d want 0 0 1", bus.BUSY,
                              bus.WORD_COUNT, wr_q.size());
        end
        wq.delete();
        drive_session(ADDR_W'(0), 0, 0, 1'b0, 1'b0, ok);
        n_cmp++;
        if (!ok || done_q.size() != 1 || bus.WORD_COUNT !== '0 || wr_q.size() != 0) begin
            n_bad++; $display("FAIL rstmid_len0: got %0d done wc=%0d writes=%0d want 1 0 0", done_q.size(),
                              bus.WORD_COUNT, wr_q.size());
        end
    endtask

    // Random sessions with stray START during the session and ABORT alongside START.
    task automatic test_random();
        bit ok;
        logic [ADDR_W-1:0] base;
        logic [ADDR_W-1:0] ea;
        logic [7:0] ed;
        int n;
        for (int s = 0; s < 8; s++) begin
            base = ADDR_W'($urandom_range(255, 0) * 4);
            n = $urandom_range(5, 1);
            wq.delete();
            for (int i = 0; i < n; i++) wq.push_back($urandom);
            drive_session(base, 0, 3, 1'b1, $urandom_range(1, 0) == 1, ok);
            n_cmp++;
            if (!ok || wr_q.size() != 4 * n || hs_q.size() != n) begin
                n_bad++; $display("FAIL rand%0d_nwrites: got %0d ok=%0b want %0d", s, wr_q.size(), ok, 4 * n);
                continue;
            end
            for (int j = 0; j < 4 * n; j++) begin
                model_byte(base, j, ea, ed);
                n_cmp++;
                if (wr_q[j].addr !== ea || wr_q[j].data !== ed || wr_q[j].cyc !== hs_q[j/4] + 1 + j%4) begin
                    n_bad++; $display("FAIL rand%0d_byte%0d: got (%0d,%h)@%0d want (%0d,%h)@%0d", s, j,
                                      wr_q[j].addr, wr_q[j].data, wr_q[j].cyc, ea, ed, hs_q[j/4] + 1 + j%4);
                end
            end
            n_cmp++;
            if (done_q.size() != 1 || done_q[0] != hs_q[n-1] + 5 || bus.WORD_COUNT !== LEN_W'(n)
                || align_cnt != 0) begin
                n_bad++; $display("FAIL rand%0d_end: got %0d done wc=%0d ae=%0d want 1 %0d 0", s,
                                  done_q.size(), bus.WORD_COUNT, align_cnt, n);
            end
        end
    endtask

    initial begin
        bus.START     = 1'b0;
        bus.BASE_ADDR = '0;
        bus.LOAD_LEN  = '0;
        bus.ABORT     = 1'b0;
        bus.WR_VALID  = 1'b0;
        bus.WR_DATA   = '0;
        test_reset();
        test_single();
        test_wrap();
        test_gap();
        test_align();
        test_abort();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
